// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants for the nibble-serial adder
// Purpose: FSM state encoding and the width of the shared adder slice.
// Ports: none (package).
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_four_adder.sv
// rtl/nibble_serial_adder_four_adder.sv - 4-bit ripple-carry adder cell
// Purpose: sum = a + b + c_in over one nibble, carry rippled bit by bit.
// Ports:
//   sum   out 4  nibble sum
//   c_out out 1  carry out of bit 3
//   c_in  in  1  carry into bit 0
//   a, b  in  4  nibble operands
module four_adder
    import nibble_serial_adder_pkg::*;
(
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out,
    input  logic                c_in,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b
);

    logic [NIBBLE_W:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder built on one 4-bit adder
// Purpose: adds one nibble per clock, LSB first, carry chained through a register.
//   Optional macro SUBTRACT_EN adds a 'sub' port selecting a - b.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, sampled only when not busy
//   a, b, c_in     operands, captured on an accepted start
//   sub            (SUBTRACT_EN only) 1 = subtract, captured with the operands
//   busy           high while the nibbles are being processed
//   done           one-cycle pulse when sum/c_out/overflow are updated
//   sum, c_out     registered result and carry out of the MSB nibble
//   overflow       two's-complement overflow of the last operation
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam int ACC_W   = WIDTH - NIBBLE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic               sub_eff;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic               nib_cout;
    logic [WIDTH-1:0]   full_sum;

`ifdef SUBTRACT_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign nib_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

    four_adder u_adder (
        .sum   (nib_sum),
        .c_out (nib_cout),
        .c_in  (carry_q),
        .a     (nib_a),
        .b     (nib_b)
    );

    // Finished nibbles shift in from the top of acc, so after the last
    // nibble the full result is simply {current nibble, acc}.
    assign full_sum = {nib_sum, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_RUN: begin
                acc_d   = full_sum[WIDTH-1:NIBBLE_W];
                carry_d = nib_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    sum_d   = full_sum;
                    c_out_d = nib_cout;
                    // b_q is already the effective (possibly inverted) operand.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accept in IDLE and DONE alike so back-to-back operations have no bubble.
        if (start && (state_q != S_RUN)) begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = sub_eff ? ~b : b;
            carry_d = sub_eff | c_in;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        c_in;
    logic        sub;
    logic        busy, done;
    logic [15:0] sum;
    logic        c_out, overflow;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef SUBTRACT_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] held = '0;
    bit          scramble = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer plus a guard that the sum port never moves during RUN.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) check("sum_hold_during_run", {16'h0, sum}, {16'h0, held});
            else held = sum;
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, ".sum"}, {16'h0, sum}, {16'h0, e.s});
                    check({e.tag, ".c_out"}, {31'h0, c_out}, {31'h0, e.co});
                    check({e.tag, ".overflow"}, {31'h0, overflow}, {31'h0, e.ov});
                end
            end
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ici,
                         input logic isub, input logic [15:0] es, input logic eco,
                         input logic eov, input string tag);
        exp_t e;
        a     = ia;
        b     = ib;
        c_in  = ici;
        sub   = isub;
        start = 1'b1;
        e.s = es; e.co = eco; e.ov = eov; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                a    = 16'($urandom);
                b    = 16'($urandom);
                c_in = 1'($urandom);
                sub  = 1'($urandom);
            end
            lat++;
        end while (!done && lat < 20);
        check({tag, ".latency"}, lat, 5);
    endtask

    function automatic vec_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mci, input logic msub);
        vec_t v;
        logic [15:0] bb;
        logic [16:0] r;
        bb = msub ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, bb} + {16'h0, (msub | mci)};
        v.a = ma; v.b = mb; v.cin = mci; v.sub = msub;
        v.s  = r[15:0];
        v.co = r[16];
        v.ov = (ma[15] == bb[15]) && (r[15] != ma[15]);
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   n;

        tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});
`ifdef SUBTRACT_EN
        tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
        tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", {31'h0, busy}, 0);
        check("reset.done", {31'h0, done}, 0);
        check("reset.sum", {16'h0, sum}, 0);
        check("reset.c_out", {31'h0, c_out}, 0);
        check("reset.overflow", {31'h0, overflow}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                  tbl[i].s, tbl[i].co, tbl[i].ov, $sformatf("vec%0d", i));
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Back-to-back: second start presented in the DONE cycle.
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "b2b_first");
        wait_done("b2b_first");
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "b2b_second");
        wait_done("b2b_second");
        @(negedge clk);

        // start pulsed in RUN cycle 2 must be dropped.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, "ignore");
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
        end while (!done && n < 20);
        check("ignore.latency", n, 5);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        check("ignore.extra_done", n, 0);

        // Reset in RUN cycle 2 aborts; outputs were non-zero beforehand.
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pre_abort");
        wait_done("pre_abort");
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "aborted");
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort.busy", {31'h0, busy}, 0);
        check("abort.done", {31'h0, done}, 0);
        check("abort.sum", {16'h0, sum}, 0);
        check("abort.c_out", {31'h0, c_out}, 0);
        check("abort.overflow", {31'h0, overflow}, 0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort.no_done", n, 0);

        // Random operations; inputs are scrambled while the operation runs.
        scramble = 1'b1;
        for (int i = 0; i < 30; i++) begin
            vec_t v;
            logic rsub;
`ifdef SUBTRACT_EN
            rsub = 1'($urandom);
`else
            rsub = 1'b0;
`endif
            v = model(16'($urandom), 16'($urandom), 1'($urandom), rsub);
            issue(v.a, v.b, v.cin, v.sub, v.s, v.co, v.ov, $sformatf("rand%0d", i));
            wait_done($sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end
        scramble = 1'b0;
        start = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
